// File: rtl/im_fetch_ctrl.sv
// rtl/im_fetch_ctrl.sv - instruction-fetch sequencer with 2-entry fetch queue and redirect flush
// Optional out-of-range fetch check: define IM_FETCH_ADDR_CHECK_EN.
module im_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          IM_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [9:0]  im_addr,
    input  logic [31:0] im_dout,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    output logic [31:0] fetch_cnt,
    output logic [1:0]  state,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10,
        S_ERR  = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc;
    logic [1:0]  count;
    logic [31:0] q0_pc, q0_instr, q1_pc, q1_instr;
    logic        pop, push_req, push, range_err, wr_slot1;

    if (IM_WORDS < 1 || IM_WORDS > 1024) begin : g_bad_words
        $error("IM_WORDS must be within 1..1024");
    end

    // Byte-offset bits of the redirect target are dropped by word alignment.
    logic unused_redirect_bits;
    assign unused_redirect_bits = &{1'b0, redirect_pc[1:0]};

    assign im_addr  = pc[11:2];
    assign if_valid = (count != 2'd0);
    assign if_pc    = q0_pc;
    assign if_instr = q0_instr;
    assign state    = state_q;

    assign pop      = if_valid && id_ready;
    assign push_req = (state_q == S_RUN) && !redirect_valid && ((count != 2'd2) || pop);

`ifdef IM_FETCH_ADDR_CHECK_EN
    logic [29:0] word_off;
    // Addresses below RESET_PC wrap to a huge offset and are caught as well.
    assign word_off  = pc[31:2] - RESET_PC[31:2];
    assign range_err = push_req && (word_off >= 30'(IM_WORDS));
`else
    assign range_err = 1'b0;
`endif

    assign push     = push_req && !range_err;
    // After the pop shift, the new word lands right behind what remains.
    assign wr_slot1 = ((count == 2'd2) && pop) || ((count == 2'd1) && !pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!redirect_valid) begin
            case (state_q)
                S_IDLE:  if (start) state_d = S_RUN;
                S_RUN: begin
                    if (range_err)  state_d = S_ERR;
                    else if (halt)  state_d = S_HALT;
                end
                S_HALT:  if (start) state_d = S_RUN;
                default: state_d = S_ERR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            count     <= 2'd0;
            q0_pc     <= 32'd0;
            q0_instr  <= 32'd0;
            q1_pc     <= 32'd0;
            q1_instr  <= 32'd0;
            fetch_cnt <= 32'd0;
            addr_err  <= 1'b0;
        end else if (redirect_valid) begin
            count <= 2'd0;
            pc    <= {redirect_pc[31:2], 2'b00};
        end else begin
            if (range_err) begin
                addr_err <= 1'b1;
            end
            if (pop && (count == 2'd2)) begin
                q0_pc    <= q1_pc;
                q0_instr <= q1_instr;
            end
            if (push) begin
                if (wr_slot1) begin
                    q1_pc    <= pc;
                    q1_instr <= im_dout;
                end else begin
                    q0_pc    <= pc;
                    q0_instr <= im_dout;
                end
                pc        <= pc + 32'd4;
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// tb/tb_im_fetch_ctrl.sv - randomized bench for im_fetch_ctrl against a queue-based reference model
module tb_im_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int          IM_WORDS = 128;

    logic        clk = 1'b0;
    logic        rst, start, halt, redirect_valid, id_ready;
    logic [31:0] redirect_pc;
    logic [9:0]  im_addr;
    logic [31:0] im_dout;
    logic        if_valid;
    logic [31:0] if_instr, if_pc, fetch_cnt;
    logic [1:0]  state;
    logic        addr_err;

    logic [31:0] mem [1024];

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: architectural view of the fetcher.
    int          m_state;
    logic [31:0] m_pc, m_fc, m_disp_pc, m_disp_ins;
    logic        m_err;
    logic [31:0] m_qpc [$];
    logic [31:0] m_qins [$];

    im_fetch_ctrl #(.RESET_PC(RESET_PC), .IM_WORDS(IM_WORDS)) dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .im_addr(im_addr), .im_dout(im_dout),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .fetch_cnt(fetch_cnt), .state(state),
        .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    always_comb im_dout = mem[im_addr];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state    = 0;
        m_pc       = RESET_PC;
        m_fc       = 0;
        m_err      = 1'b0;
        m_disp_pc  = 0;
        m_disp_ins = 0;
        m_qpc.delete();
        m_qins.delete();
    endtask

    function automatic bit out_of_range(input logic [31:0] p);
`ifdef IM_FETCH_ADDR_CHECK_EN
        logic [29:0] off;
        off = 30'((p >> 2) - (RESET_PC >> 2));
        return off >= 30'(IM_WORDS);
`else
        return (p == 32'hFFFF_FFFF) && (p != 32'hFFFF_FFFF);
`endif
    endfunction

    task automatic model_step(input logic r, s, h, rv, input logic [31:0] rp, input logic rd);
        bit do_pop, do_push;
        int nxt;
        if (r) begin
            model_reset();
            return;
        end
        if (rv) begin
            m_qpc.delete();
            m_qins.delete();
            m_pc = {rp[31:2], 2'b00};
            return;
        end
        do_pop  = (m_qpc.size() > 0) && rd;
        do_push = (m_state == 1) && ((m_qpc.size() < 2) || do_pop);
        nxt = m_state;
        if (m_state == 0 && s) nxt = 1;
        if (m_state == 1 && h) nxt = 2;
        if (m_state == 2 && s) nxt = 1;
        if (do_push && out_of_range(m_pc)) begin
            do_push = 0;
            nxt     = 3;
            m_err   = 1'b1;
        end
        m_state = nxt;
        if (do_pop) begin
            void'(m_qpc.pop_front());
            void'(m_qins.pop_front());
        end
        if (do_push) begin
            m_qpc.push_back(m_pc);
            m_qins.push_back(mem[m_pc[11:2]]);
            m_pc = m_pc + 4;
            m_fc = m_fc + 1;
        end
        if (m_qpc.size() > 0) begin
            m_disp_pc  = m_qpc[0];
            m_disp_ins = m_qins[0];
        end
    endtask

    task automatic check_all();
        check_val("if_valid", {31'd0, if_valid}, {31'd0, m_qpc.size() > 0});
        check_val("if_pc", if_pc, m_disp_pc);
        check_val("if_instr", if_instr, m_disp_ins);
        check_val("fetch_cnt", fetch_cnt, m_fc);
        check_val("state", {30'd0, state}, 32'(m_state));
        check_val("im_addr", {22'd0, im_addr}, {22'd0, m_pc[11:2]});
        check_val("addr_err", {31'd0, addr_err}, {31'd0, m_err});
    endtask

    task automatic step(input logic r, s, h, rv, input logic [31:0] rp, input logic rd);
        check_all();
        rst = r; start = s; halt = h; redirect_valid = rv; redirect_pc = rp; id_ready = rd;
        model_step(r, s, h, rv, rp, rd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[i] = 32'h2008_0001 + i;

        rst = 1'b1; start = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'd0; id_ready = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        // basic stream
        step(1, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1);
        // backpressure then release
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        // redirect with full queue
        step(0, 0, 0, 1, 32'h0000_3041, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
        // halt, drain, resume
        step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
        // halt and start together in RUN, start in RUN, halt in IDLE
        step(0, 1, 1, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        // out-of-range target: ERR with the check, free wrap without
        step(0, 1, 0, 0, 0, 1);
        step(0, 0, 0, 1, RESET_PC + 4 * IM_WORDS, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, RESET_PC, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);

        for (int n = 0; n < 4000; n++) begin
            logic r, s, h, rv, rd;
            logic [31:0] rp;
            r  = ($urandom_range(0, 99) < 2);
            s  = ($urandom_range(0, 99) < 10);
            h  = ($urandom_range(0, 99) < 5);
            rv = ($urandom_range(0, 99) < 7);
            rd = ($urandom_range(0, 99) < 65);
            rp = RESET_PC + ($urandom_range(0, 150) << 2) + $urandom_range(0, 3);
            if ($urandom_range(0, 19) == 0) rp = $urandom;
            step(r, s, h, rv, rp, rd);
        end
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/im_fetch_ctrl.md
Name: im_fetch_ctrl

Overview:
- Instruction-fetch sequencer between PC logic and the combinational instruction memory, which takes a word address [11:2] and returns a 32-bit word in the same cycle.
- Owns the PC and drives the IM address.
- Buffers fetched words in a 2-entry queue.
- Presents them to the IF/ID register with a valid/ready handshake, and handles start, halt and branch/jump redirect with queue flush.

Parameters:
- RESET_PC, 32'h0000_3000, PC loaded on reset.
- IM_WORDS, 128, number of valid IM words; used only by the optional check.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; IDLE -> RUN.
- halt  in  1  level/pulse; RUN -> HALT.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  target byte address.
- im_addr  out  10  word address to IM (pc[11:2]).
- im_dout  in  32  IM read data, combinational from im_addr.
- if_valid  out  1  queue head valid.
- if_instr  out  32  head instruction.
- if_pc  out  32  head PC.
- id_ready  in  1  ID stage accepts the head this cycle.
- fetch_cnt  out  32  number of pushes since reset; wraps.
- state  out  2  00 IDLE, 01 RUN, 10 HALT, 11 ERR (ERR only with the optional feature).
- addr_err  out  1  out-of-range fetch flag (tied 0 without the optional feature).

Behaviour:
- Reset, all at the next clk edge with rst=1: state=IDLE, pc=RESET_PC, queue count=0, if_valid=0, if_instr=0, if_pc=0, fetch_cnt=0, addr_err=0. rst mid-operation discards everything the same way.
- im_addr = pc[11:2] at all times, combinational from the PC register.
- pop = if_valid & id_ready. The head advances at the edge and entry 1 shifts to entry 0.
- push occurs only when all hold: state==RUN, !redirect_valid, and (count<2 or pop). The pushed entry is {pc, im_dout}; pc <= pc+4 (32-bit wrap); fetch_cnt <= fetch_cnt+1.
- Simultaneous push and pop at count==2: count stays 2 and the order is preserved.
- Throughput: 1 instruction/cycle when id_ready is held high.
- Latency from start: pulse in cycle N; state=RUN after edge N; first push at edge N+1; if_valid=1 in cycle N+2 with if_pc=RESET_PC.
- Redirect, in any state, highest priority after rst:
  - At the edge: queue cleared (count=0); pc <= {redirect_pc[31:2],2'b00}; no push.
  - Any pop that cycle is void, but ID's sampling of the head that cycle is its own concern.
  - State is unchanged.
- halt in RUN: state <= HALT at the edge. Pushes stop from the next cycle; a push in the halt cycle itself still occurs. The queue keeps draining.
- start in HALT: back to RUN. start in RUN is ignored. halt in IDLE is ignored. halt and start together in RUN resolve to HALT.
- Queue full and id_ready=0: no push, pc holds, outputs hold stable (no combinational dependence of if_* on id_ready).
- if_instr and if_pc hold their last value when if_valid=0; they are cleared only by rst.

Optional Feature:
- Macro: IM_FETCH_ADDR_CHECK_EN.
- Defined: a push whose pc[31:2] relative to RESET_PC[31:2] lies at or beyond IM_WORDS words is suppressed. Instead: state <= ERR, addr_err <= 1 (sticky until rst). Queued entries still drain. redirect does not leave ERR; only rst does.
- Undefined: no check; addr_err is tied 0; ERR is unreachable; the PC wraps freely over the 10-bit im_addr.

Test Plan:
- Basic stream:
  - Stimulus: rst 2 cycles; start; id_ready=1; IM[0..3]=0x20080001..0x20080004.
  - Required: if_valid first high 2 cycles after start; if_pc 0x3000, 0x3004, 0x3008, 0x300C on consecutive cycles; if_instr matches; fetch_cnt=4 after 4 pushes.
- Backpressure:
  - Stimulus: id_ready=0 for 5 cycles after start.
  - Required: count saturates at 2; pc holds at 0x3008; if_pc stays 0x3000. Releasing id_ready yields 0x3000, 0x3004, 0x3008 with no loss or duplication.
- Redirect flush:
  - Stimulus: queue full with 0x3004/0x3008; redirect_valid=1, redirect_pc=0x3041.
  - Required: next cycle if_valid=0; following cycle if_pc=0x3040, if_instr=IM[16].
- Halt/resume:
  - Stimulus: halt while pc=0x3010.
  - Required: at most one more push (0x3010); queue drains; if_valid falls; state=10. start resumes with if_pc=0x3014.
- Reset mid-run:
  - Stimulus: rst with count=2 and fetch_cnt=7.
  - Required: next cycle state=00, if_valid=0, fetch_cnt=0, im_addr=RESET_PC[11:2]=10'h000. No fetch until start.
- With IM_FETCH_ADDR_CHECK_EN:
  - Stimulus: redirect_pc=0x3000+4*128.
  - Required: no push; state=11; addr_err=1 held through further redirects until rst.
